// File: rtl/sar_logic.sv
// Successive-approximation register controller: sample phase, MSB-first binary
// search on the comparator decision, then a one-cycle done with the held result.
module sar_logic #(
    parameter int unsigned Ndac  = 16,
    parameter int unsigned Nsamp = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            invert_cfg,
    input  logic            comp_out,
    output logic            samp,
    output logic            comp_strobe,
    output logic [Ndac-1:0] dac_state,
    output logic            dac_drive_invert,
    output logic            busy,
    output logic            done,
    output logic [Ndac-1:0] result
);

    localparam int unsigned IW = (Ndac > 1) ? $clog2(Ndac) : 1;
    localparam int unsigned CW = (Nsamp > 1) ? $clog2(Nsamp) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [Ndac-1:0] dac_q, dac_d;
    logic [Ndac-1:0] result_q, result_d;
    logic            inv_q, inv_d;
    logic            samp_q, samp_d;
    logic            strobe_q, strobe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dac_d    = dac_q;
        result_d = result_q;
        inv_d    = inv_q;
        samp_d   = samp_q;
        busy_d   = busy_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SAMPLE;
                    dac_d   = {1'b1, {(Ndac-1){1'b0}}};
                    inv_d   = invert_cfg;
                    busy_d  = 1'b1;
                    samp_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = IW'(Ndac - 1);
                end
            end
            S_SAMPLE: begin
                if (cnt_q == CW'(Nsamp - 1)) begin
                    state_d  = S_STROBE;
                    samp_d   = 1'b0;
                    strobe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE: begin
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                // comp_out answers the trial that was strobed one cycle earlier
                dac_d[idx_q] = comp_out;
                if (idx_q != '0) begin
                    dac_d[idx_q - IW'(1)] = 1'b1;
                    idx_d    = idx_q - IW'(1);
                    state_d  = S_STROBE;
                    strobe_d = 1'b1;
                end else begin
                    result_d = dac_d;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= IW'(Ndac - 1);
            dac_q    <= '0;
            result_q <= '0;
            inv_q    <= 1'b0;
            samp_q   <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            inv_q    <= inv_d;
            samp_q   <= samp_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign samp             = samp_q;
    assign comp_strobe      = strobe_q;
    assign dac_state        = dac_q;
    assign dac_drive_invert = inv_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign result           = result_q;

endmodule

// File: tb/tb_sar_logic.sv
// Scoreboard bench for sar_logic: a small 4-bit instance for directed/random
// checks and a 16-bit instance for long random runs.
module tb_sar_logic;

    localparam int ND  = 4;
    localparam int NS  = 2;
    localparam int NDB = 16;
    localparam int NSB = 1;

    typedef struct {
        int res;
        int inv;
        int t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, expv, expv, cyc);
        end
    endtask

    // ---------------- instance A (Ndac=4, Nsamp=2)
    logic          start_a, inv_a, comp_a, samp_a, strobe_a, drv_a, busy_a, done_a;
    logic [ND-1:0] dac_a, res_a, vin_a;
    int            mode_a;

    assign comp_a = (mode_a == 0) ? (vin_a >= dac_a) : (mode_a == 1);

    sar_logic #(.Ndac(ND), .Nsamp(NS)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .invert_cfg(inv_a), .comp_out(comp_a),
        .samp(samp_a), .comp_strobe(strobe_a), .dac_state(dac_a),
        .dac_drive_invert(drv_a), .busy(busy_a), .done(done_a), .result(res_a)
    );

    // ---------------- instance B (Ndac=16, Nsamp=1)
    logic           start_b, inv_b, comp_b, samp_b, strobe_b, drv_b, busy_b, done_b;
    logic [NDB-1:0] dac_b, res_b, vin_b;

    assign comp_b = (vin_b >= dac_b);

    sar_logic #(.Ndac(NDB), .Nsamp(NSB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .invert_cfg(inv_b), .comp_out(comp_b),
        .samp(samp_b), .comp_strobe(strobe_b), .dac_state(dac_b),
        .dac_drive_invert(drv_b), .busy(busy_b), .done(done_b), .result(res_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   exp_trials[$];
    bit   act_a = 1'b0;
    int   cur_inv_a = 0;

    // Behavioural model: a binary search against vin converges to vin itself.
    function automatic int ref_result(input int vin, input int mode, input int nbits);
        if (mode == 0) return vin;
        if (mode == 1) return (1 << nbits) - 1;
        return 0;
    endfunction

    // Monitor A: protocol checks every cycle, scoreboard pop on done
    int sampn_a = 0;
    int strn_a  = 0;
    always @(negedge clk) begin : mon_a
        exp_t e;
        int   tb;
        if (!act_a) begin
            sampn_a = 0;
            strn_a  = 0;
            chk("unexpected_done_a", int'(done_a), 0);
        end else begin
            chk("busy_during_conv", int'(busy_a), 1);
            chk("drive_invert_latched", int'(drv_a), cur_inv_a);
            if (samp_a) sampn_a++;
            if (strobe_a && q_a.size() > 0) begin
                tb = ND - 1 - strn_a;
                chk("strobe_cycle", cyc - q_a[0].t0, NS + 1 + 2 * strn_a);
                if (tb >= 0) begin
                    chk("trial_bit_set", (int'(dac_a) >> tb) & 1, 1);
                    chk("trial_low_zero", int'(dac_a) & ((1 << tb) - 1), 0);
                end
                if (exp_trials.size() > 0) chk("trial_code", int'(dac_a), exp_trials.pop_front());
                strn_a++;
            end
            if (done_a) begin
                if (q_a.size() == 0) begin
                    chk("done_without_expect_a", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    chk("result_a", int'(res_a), e.res);
                    chk("dac_final_a", int'(dac_a), e.res);
                    chk("latency_a", cyc - e.t0, NS + 2 * ND + 1);
                    chk("samp_cycles_a", sampn_a, NS);
                    chk("strobe_count_a", strn_a, ND);
                end
            end
        end
    end

    // Monitor B: scoreboard pop on done
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (done_b) begin
            if (q_b.size() == 0) begin
                chk("done_without_expect_b", 1, 0);
            end else begin
                e = q_b.pop_front();
                chk("result_b", int'(res_b), e.res);
                chk("latency_b", cyc - e.t0, NSB + 2 * NDB + 1);
            end
        end
    end

    task automatic conv_a(input int vin, input int mode, input int inv,
                          input bit spam, input bit toggle);
        int exp_res;
        int t0;
        int n;
        bit seen;
        exp_res = ref_result(vin, mode, ND);
        @(negedge clk);
        vin_a   = ND'(vin);
        mode_a  = mode;
        inv_a   = inv[0];
        start_a = 1'b1;
        t0      = cyc;
        @(posedge clk);
        #1;
        q_a.push_back('{res: exp_res, inv: inv, t0: t0});
        cur_inv_a = inv;
        act_a     = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            start_a = spam;
            if (toggle) inv_a = ~inv_a;
            if (done_a) seen = 1'b1;
            n++;
        end
        if (!seen) chk("timeout_done_a", 0, 1);
        @(posedge clk);
        #1;
        act_a = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        chk("idle_busy_a", int'(busy_a), 0);
        chk("idle_dac_hold_a", int'(dac_a), exp_res);
        chk("idle_result_hold_a", int'(res_a), exp_res);
        @(negedge clk);
        chk("idle_busy2_a", int'(busy_a), 0);
    endtask

    task automatic conv_b(input int vin);
        int t0;
        int n;
        bit seen;
        @(negedge clk);
        vin_b   = NDB'(vin);
        inv_b   = 1'($urandom);
        start_b = 1'b1;
        t0      = cyc;
        @(posedge clk);
        #1;
        q_b.push_back('{res: vin, inv: 0, t0: t0});
        @(negedge clk);
        start_b = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            if (done_b) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) chk("timeout_done_b", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; inv_a = 1'b0; vin_a = '0; mode_a = 0;
        start_b = 1'b0; inv_b = 1'b0; vin_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_samp", int'(samp_a), 0);
        chk("rst_strobe", int'(strobe_a), 0);
        chk("rst_dac", int'(dac_a), 0);
        chk("rst_drv", int'(drv_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_result", int'(res_a), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        chk("rst_dac_b", int'(dac_b), 0);
        rst = 1'b0;
        @(negedge clk);

        // Worked example: vin=10
        exp_trials.push_back(8);
        exp_trials.push_back(12);
        exp_trials.push_back(10);
        exp_trials.push_back(11);
        conv_a(10, 0, 0, 1'b0, 1'b0);
        chk("trials_consumed", exp_trials.size(), 0);

        // Comparator stuck high / low
        conv_a(0, 1, 0, 1'b0, 1'b0);
        conv_a(0, 2, 0, 1'b0, 1'b0);

        // start held every cycle, including the DONE cycle
        conv_a(5, 0, 0, 1'b1, 1'b0);

        // Polarity latched at start; toggling mid-conversion has no effect
        conv_a(3, 0, 1, 1'b0, 1'b1);
        conv_a(9, 0, 0, 1'b0, 1'b1);

        // Async reset in DECIDE of bit 2
        @(negedge clk);
        vin_a = 4'd13; mode_a = 0; inv_a = 1'b1; start_a = 1'b1;
        @(posedge clk);
        #1;
        q_a.push_back('{res: 13, inv: 1, t0: cyc - 1});
        cur_inv_a = 1;
        act_a     = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_trial", int'(dac_a), 4'b1100);
        #1;
        rst = 1'b1;
        #1;
        q_a.delete();
        act_a = 1'b0;
        chk("abort_samp", int'(samp_a), 0);
        chk("abort_strobe", int'(strobe_a), 0);
        chk("abort_dac", int'(dac_a), 0);
        chk("abort_drv", int'(drv_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_result", int'(res_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        conv_a(13, 0, 1, 1'b0, 1'b0);

        // Random mix on the small instance
        for (int k = 0; k < 30; k++) begin
            conv_a(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom));
        end

        // Long random run on the 16-bit instance
        for (int k = 0; k < 1000; k++) begin
            conv_b(int'($urandom_range(0, 65535)));
        end

        repeat (3) @(negedge clk);
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
